core_wb_master: RTL and testbench

- Core-side Wishbone master adapter sitting directly upstream of the SoC top core port; drives core_soc_cyc/stb/we/addr/wdata/sel and consumes core_soc_rdata/ack.
- Accepts valid/ready load/store requests from the core LSU and buffers them in a small FIFO.
- Issues exactly one Wishbone classic cycle at a time and returns one response per request, in order.
- Adds misalignment rejection and a bus timeout so a non-acking slave can never hang the core.

---
 rtl/core_wb_master.sv | 203 ++++++++++++++++++++
 tb/tb_core_wb_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_master.sv
// core_wb_master
// Core-side Wishbone classic master adapter. Load/store requests from the LSU
// are buffered in a small FIFO and issued one Wishbone cycle at a time. Each
// request gets exactly one response, in order. Misaligned requests are rejected
// without touching the bus. A bus timeout aborts a cycle that a slave never acks.
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | no cycle in flight; launch or reject the FIFO head
// BUS   | Wishbone cycle in flight; waiting for ack or timeout
// RESP  | response presented; waiting for resp_ready_i
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req_valid_i/req_ready_o         request handshake (ready = FIFO not full)
//   req_we_i/addr_i/wdata_i/sel_i   request payload
//   resp_valid_o/resp_ready_i       response handshake
//   resp_rdata_o/resp_err_o         response payload
//   wbm_*                           Wishbone classic master port
//   busy_o                          requests pending or FSM active
module core_wb_master #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [DW-1:0]   resp_rdata_o,
  output logic            resp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_addr_o,
  output logic [DW-1:0]   wbm_wdata_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_rdata_i,
  input  logic            wbm_ack_i,
  output logic            busy_o
);

  localparam int SW = DW / 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Request FIFO. The head stays in the FIFO while its bus cycle is in flight,
  // so the in-flight request counts against FIFO_DEPTH.
  logic          fifo_we    [FIFO_DEPTH];
  logic [AW-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DW-1:0] fifo_wdata [FIFO_DEPTH];
  logic [SW-1:0] fifo_sel   [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;
  logic [SW-1:0] head_sel;
  logic          misaligned;

  // Timeout as a down-counter: loaded on launch, expires at zero.
  logic [TW-1:0] to_cnt;
  logic          expired;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign push        = req_valid_i && !full;
  assign req_ready_o = !full;
  assign busy_o      = !empty || (state != IDLE);

  assign head_we    = fifo_we[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  assign head_sel   = fifo_sel[rd_ptr];
  assign misaligned = (head_addr[1:0] != 2'b00);

  assign expired = (TIMEOUT_CYCLES != 0) && (to_cnt == '0);

  // Pop happens on completion of the head, never at launch.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty && misaligned;
      BUS:     pop = wbm_ack_i || expired;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we_i;
      fifo_addr[wr_ptr]  <= req_addr_i;
      fifo_wdata[wr_ptr] <= req_wdata_i;
      fifo_sel[wr_ptr]   <= req_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_addr_o   <= '0;
      wbm_wdata_o  <= '0;
      wbm_sel_o    <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (misaligned) begin
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
              state        <= RESP;
            end else begin
              wbm_cyc_o   <= 1'b1;
              wbm_stb_o   <= 1'b1;
              wbm_we_o    <= head_we;
              wbm_addr_o  <= head_addr;
              wbm_wdata_o <= head_wdata;
              wbm_sel_o   <= head_sel;
              to_cnt      <= TO_LOAD;
              state       <= BUS;
            end
          end
        end
        BUS: begin
          // Ack has priority over a coincident timeout.
          if (wbm_ack_i) begin
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= wbm_we_o ? '0 : wbm_rdata_i;
            state        <= RESP;
          end else if (expired) begin
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
            state        <= RESP;
          end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_master.sv
// tb_core_wb_master
// Scoreboard bench for core_wb_master (FIFO_DEPTH=2, TIMEOUT_CYCLES=8).
// Stimulus drives at posedge+2, the slave model at posedge+1, monitors sample
// at negedge. Expected responses and bus cycles are queued on acceptance.
module tb_core_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_addr;
  logic [31:0] wbm_wdata;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_rdata = 32'hDEAD_BEEF;
  logic        wbm_ack = 1'b0;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dur;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];

  int ack_delay = 1;   // 0 = slave never acks
  int slv_cnt   = 0;
  int bus_done  = 0;

  core_wb_master #(
    .AW(32), .DW(32), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_addr_o(wbm_addr), .wbm_wdata_o(wbm_wdata), .wbm_sel_o(wbm_sel),
    .wbm_rdata_i(wbm_rdata), .wbm_ack_i(wbm_ack), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hA5A5_5A5A;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave: acks in the ack_delay-th cycle of cyc; rdata is junk when not acking.
  always @(posedge clk) begin
    #1;
    if (!wbm_cyc) begin
      slv_cnt = 0;
      wbm_ack = 1'b0;
    end else begin
      slv_cnt++;
      wbm_ack = (ack_delay != 0) && (slv_cnt == ack_delay);
    end
    wbm_rdata = wbm_ack ? slave_data(wbm_addr) : 32'hDEAD_BEEF;
  end

  // Response monitor with stability check while stalled.
  logic        hold_v = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("resp_hold_valid", resp_valid, 1);
        chk("resp_hold_rdata", resp_rdata, hold_rdata);
        chk("resp_hold_err", resp_err, hold_err);
      end
      if (resp_valid && resp_ready) begin
        hold_v = 1'b0;
        if (resp_q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
        end
      end else if (resp_valid) begin
        hold_v     = 1'b1;
        hold_rdata = resp_rdata;
        hold_err   = resp_err;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Bus monitor: fields at launch, stability, stb==cyc, cycle length.
  logic bus_act = 1'b0;
  int   bus_dur = 0;
  bus_t cur;
  always @(negedge clk) begin
    if (rst) begin
      bus_act = 1'b0;
    end else begin
      chk("stb_eq_cyc", wbm_stb, wbm_cyc);
      if (wbm_cyc && !bus_act) begin
        bus_act = 1'b1;
        bus_dur = 1;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_cycle", 1, 0);
          cur = '{we: wbm_we, addr: wbm_addr, wdata: wbm_wdata, sel: wbm_sel, dur: 0};
        end else begin
          cur = bus_q.pop_front();
          chk("bus_we", wbm_we, cur.we);
          chk("bus_addr", wbm_addr, cur.addr);
          chk("bus_wdata", wbm_wdata, cur.wdata);
          chk("bus_sel", wbm_sel, cur.sel);
        end
      end else if (wbm_cyc) begin
        bus_dur++;
        chk("bus_stable", (wbm_we == cur.we) && (wbm_addr == cur.addr) &&
            (wbm_wdata == cur.wdata) && (wbm_sel == cur.sel), 1);
      end else if (bus_act) begin
        bus_act = 1'b0;
        bus_done++;
        if (cur.dur != 0) chk("bus_cycle_len", bus_dur, cur.dur);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, input logic [31:0] exp_rdata, input logic exp_err,
                      input bit on_bus, input int exp_dur);
    int waited;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    waited    = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 200) begin
        chk("push_accept_timeout", 0, 1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    resp_q.push_back('{rdata: exp_rdata, err: exp_err});
    if (on_bus) bus_q.push_back('{we: we, addr: addr, wdata: wdata, sel: sel, dur: exp_dur});
    #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (resp_q.size() == 0 && bus_q.size() == 0 && !busy) break;
      n++;
      if (n > 300) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    int done0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_cyc", wbm_cyc, 0);
    chk("rst_stb", wbm_stb, 0);
    chk("rst_we", wbm_we, 0);
    chk("rst_addr", wbm_addr, 0);
    chk("rst_wdata", wbm_wdata, 0);
    chk("rst_sel", wbm_sel, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;

    // 1: aligned load, slave acks in 3rd cycle
    ack_delay = 3;
    push(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hA5A5_5A5A, 1'b0, 1'b1, 3);
    drain();

    // 2: three stores, stalled slave, FIFO fills
    ack_delay = 5;
    done0 = bus_done;
    push(1'b1, 32'h0000_2000, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b1, 5);
    push(1'b1, 32'h0000_2004, 32'h2222_2222, 4'h3, 32'h0, 1'b0, 1'b1, 5);
    @(negedge clk);
    chk("full_ready_low", req_ready, 0);
    chk("full_busy", busy, 1);
    @(posedge clk); #2;
    push(1'b1, 32'h0000_2008, 32'h3333_3333, 4'hC, 32'h0, 1'b0, 1'b1, 5);
    chk("third_after_first_ack", (bus_done - done0) >= 1, 1);
    drain();

    // 3: misaligned load, no bus cycle
    push(1'b0, 32'h0000_1002, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 0);
    drain();

    // 4: timeout, then ack coinciding with expiry
    ack_delay = 0;
    push(1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 8);
    drain();
    ack_delay = 8;
    push(1'b0, 32'h0000_3004, 32'h0, 4'hF, 32'h3004_CFFB, 1'b0, 1'b1, 8);
    drain();

    // 5: response stalled, FIFO keeps accepting until full
    ack_delay  = 1;
    resp_ready = 1'b0;
    push(1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h4000_BFFF, 1'b0, 1'b1, 1);
    push(1'b1, 32'h0000_4004, 32'h4444_4444, 4'hF, 32'h0, 1'b0, 1'b1, 1);
    push(1'b0, 32'h0000_4008, 32'h0, 4'h1, 32'h4008_BFF7, 1'b0, 1'b1, 1);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("stall_resp_valid", resp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_bus", wbm_cyc, 0);
      chk("stall_ready_low", req_ready, 0);
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    drain();

    // 6: reset during BUS
    ack_delay = 0;
    push(1'b0, 32'h0000_5000, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 0);
    n = 0;
    while (!wbm_cyc && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rst6_cyc_seen", wbm_cyc, 1);
    cycles(2);
    rst = 1'b1;
    resp_q.delete();
    bus_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst6_cyc", wbm_cyc, 0);
    chk("rst6_stb", wbm_stb, 0);
    chk("rst6_ready", req_ready, 1);
    chk("rst6_busy", busy, 0);
    chk("rst6_resp_valid", resp_valid, 0);
    @(posedge clk); #2;
    ack_delay = 2;
    push(1'b0, 32'h0000_5004, 32'h0, 4'hF, 32'h5004_AFFB, 1'b0, 1'b1, 2);
    drain();

    chk("resp_queue_empty", resp_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
